// File: rtl/pipe_stage_regs_pkg.sv
// Shared MIPS core constants: reset PC, control-bundle layout and the NOP encoding.
// Imported by the pipeline-register slice (pipe_stage_regs and its interface).
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          CTRL_W           = 12;

  // Bit positions inside the packed decode control bundle carried D->E.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_JUMP     = 6;
  localparam int CTRL_ALUCTRL  = 7;  // 3-bit field, bits 9:7
  localparam int CTRL_ALUCTRL_W = 3;
  localparam int CTRL_SHIFT    = 10;
  localparam int CTRL_LUI      = 11;

  // sll $0,$0,0 encodes as all zeros, so a cleared IF/ID register is a NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] pcInc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Stall/flush and fetch/decode bus between the hazard unit, the F/D datapath
// and the pipeline registers. The slave modport is the register slice.
interface pipe_stage_regs_if
  import mips_pkg::*;
#(
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 32
);

  // There is no valid/ready handshake here: StallF/StallD/FlushE/PCSrcD are
  // level controls sampled on every rising edge, and the registered outputs
  // change only on that edge (or immediately on reset).
  logic              StallF;
  logic              StallD;
  logic              FlushE;
  logic              PCSrcD;
  logic [31:0]       PCBranchD;
  logic [31:0]       InstrF;

  logic [31:0]       PCF;
  logic [31:0]       InstrD;
  logic [31:0]       PCPlus4D;
  logic              ValidD;

  logic [CTRL_W-1:0] CtrlD;
  logic [31:0]       RD1D;
  logic [31:0]       RD2D;
  logic [31:0]       SignImmD;
  logic [4:0]        RsD;
  logic [4:0]        RtD;
  logic [4:0]        RdD;

  logic [CTRL_W-1:0] CtrlE;
  logic [31:0]       RD1E;
  logic [31:0]       RD2E;
  logic [31:0]       SignImmE;
  logic [4:0]        RsE;
  logic [4:0]        RtE;
  logic [4:0]        RdE;
  logic              ValidE;

  logic [CNT_W-1:0]  StallCnt;
  logic [CNT_W-1:0]  FlushCnt;

  modport master (
    output StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
    output CtrlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    input  PCF, InstrD, PCPlus4D, ValidD,
    input  CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
    input  CtrlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    output PCF, InstrD, PCPlus4D, ValidD,
    output CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE,
    output StallCnt, FlushCnt
  );

endinterface

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Generic pipeline register with asynchronous reset, synchronous clear and
// enable; clear beats enable so a squash/bubble always lands.
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS core, driven by the hazard
// unit's stall/flush controls. Optional counters: define PIPE_PERF_CNT_EN.
module pipe_stage_regs
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CTRL_W   = mips_pkg::CTRL_W,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_stage_regs_if.slave  bus
);

  localparam int IFID_W = 1 + 32 + 32;
  localparam int IDEX_W = 1 + CTRL_W + 32 * 3 + 5 * 3;

  logic [31:0]       pcPlus4F;
  logic [31:0]       pcNext;
  logic              squashD;
  logic [IFID_W-1:0] ifidD;
  logic [IFID_W-1:0] ifidQ;
  logic [IDEX_W-1:0] idexD;
  logic [IDEX_W-1:0] idexQ;

  assign pcPlus4F = pcInc(bus.PCF);
  assign pcNext   = bus.PCSrcD ? bus.PCBranchD : pcPlus4F;

  // A stalled D keeps its instruction even if a branch resolves; the branch
  // is re-evaluated next cycle, so the squash must wait for the stall to drop.
  assign squashD = bus.PCSrcD & ~bus.StallD;

  pipe_reg #(
    .W       (32),
    .RST_VAL (RESET_PC)
  ) u_pcReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~bus.StallF),
    .clr   (1'b0),
    .d     (pcNext),
    .q     (bus.PCF)
  );

  assign ifidD = {1'b1, pcPlus4F, bus.InstrF};

  pipe_reg #(
    .W       (IFID_W),
    .RST_VAL ({1'b0, 32'd0, NOP_INSTR})
  ) u_ifidReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~bus.StallD),
    .clr   (squashD),
    .d     (ifidD),
    .q     (ifidQ)
  );

  assign bus.ValidD   = ifidQ[IFID_W-1];
  assign bus.PCPlus4D = ifidQ[63:32];
  assign bus.InstrD   = ifidQ[31:0];

  assign idexD = {bus.ValidD, bus.CtrlD, bus.RD1D, bus.RD2D, bus.SignImmD,
                  bus.RsD, bus.RtD, bus.RdD};

  // ID/EX never holds; FlushE inserts an all-zero bubble (RegWrite=MemWrite=0).
  pipe_reg #(
    .W       (IDEX_W),
    .RST_VAL ('0)
  ) u_idexReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (bus.FlushE),
    .d     (idexD),
    .q     (idexQ)
  );

  assign {bus.ValidE, bus.CtrlE, bus.RD1E, bus.RD2E, bus.SignImmE,
          bus.RsE, bus.RtE, bus.RdE} = idexQ;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;
  logic             flushEvent;

  assign flushEvent = bus.FlushE | squashD;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (bus.StallD && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if (flushEvent && (flushCnt != '1)) begin
        flushCnt <= flushCnt + 1'b1;
      end
    end
  end

  assign bus.StallCnt = stallCnt;
  assign bus.FlushCnt = flushCnt;
`else
  assign bus.StallCnt = '0;
  assign bus.FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomized and directed bench for pipe_stage_regs against an architectural
// model of the PC / IF/ID / ID/EX registers. Honours PIPE_PERF_CNT_EN.
module tb_pipe_stage_regs;

  localparam int CTRL_W = 12;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  pipe_stage_regs_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) ifc ();

  pipe_stage_regs #(
    .RESET_PC (32'h0000_0000),
    .CTRL_W   (CTRL_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Architectural expectation of every registered output.
  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       instrD;
    logic [31:0]       pc4D;
    logic              validD;
    logic [CTRL_W-1:0] ctrlE;
    logic [31:0]       rd1E;
    logic [31:0]       rd2E;
    logic [31:0]       immE;
    logic [4:0]        rsE;
    logic [4:0]        rtE;
    logic [4:0]        rdE;
    logic              validE;
    int                stallCnt;
    int                flushCnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.pc = 32'h0; r.instrD = 32'h0; r.pc4D = 32'h0; r.validD = 1'b0;
    r.ctrlE = '0; r.rd1E = 32'h0; r.rd2E = 32'h0; r.immE = 32'h0;
    r.rsE = 5'd0; r.rtE = 5'd0; r.rdE = 5'd0; r.validE = 1'b0;
    r.stallCnt = 0; r.flushCnt = 0;
    return r;
  endfunction

  // One rising edge: every register sees the pre-edge state of the others.
  function automatic model_t model_edge(input model_t c);
    model_t n = c;
    if (ifc.FlushE) begin
      n.ctrlE = '0; n.rd1E = 0; n.rd2E = 0; n.immE = 0;
      n.rsE = 0; n.rtE = 0; n.rdE = 0; n.validE = 1'b0;
    end else begin
      n.ctrlE = ifc.CtrlD; n.rd1E = ifc.RD1D; n.rd2E = ifc.RD2D; n.immE = ifc.SignImmD;
      n.rsE = ifc.RsD; n.rtE = ifc.RtD; n.rdE = ifc.RdD; n.validE = c.validD;
    end
    if (!ifc.StallD) begin
      if (ifc.PCSrcD) begin
        n.instrD = 32'h0; n.pc4D = 32'h0; n.validD = 1'b0;
      end else begin
        n.instrD = ifc.InstrF; n.pc4D = c.pc + 32'd4; n.validD = 1'b1;
      end
    end
    if (!ifc.StallF) n.pc = ifc.PCSrcD ? ifc.PCBranchD : c.pc + 32'd4;
`ifdef PIPE_PERF_CNT_EN
    if (ifc.StallD) n.stallCnt = (c.stallCnt < CNT_MAX) ? c.stallCnt + 1 : CNT_MAX;
    if (ifc.FlushE || (ifc.PCSrcD && !ifc.StallD))
      n.flushCnt = (c.flushCnt < CNT_MAX) ? c.flushCnt + 1 : CNT_MAX;
`endif
    return n;
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".PCF"},      ifc.PCF,      m.pc);
    check_eq({tag, ".InstrD"},   ifc.InstrD,   m.instrD);
    check_eq({tag, ".PCPlus4D"}, ifc.PCPlus4D, m.pc4D);
    check_eq({tag, ".ValidD"},   32'(ifc.ValidD), 32'(m.validD));
    check_eq({tag, ".CtrlE"},    32'(ifc.CtrlE),  32'(m.ctrlE));
    check_eq({tag, ".RD1E"},     ifc.RD1E,     m.rd1E);
    check_eq({tag, ".RD2E"},     ifc.RD2E,     m.rd2E);
    check_eq({tag, ".SignImmE"}, ifc.SignImmE, m.immE);
    check_eq({tag, ".RsE"},      32'(ifc.RsE),    32'(m.rsE));
    check_eq({tag, ".RtE"},      32'(ifc.RtE),    32'(m.rtE));
    check_eq({tag, ".RdE"},      32'(ifc.RdE),    32'(m.rdE));
    check_eq({tag, ".ValidE"},   32'(ifc.ValidE), 32'(m.validE));
    check_eq({tag, ".StallCnt"}, 32'(ifc.StallCnt), 32'(m.stallCnt));
    check_eq({tag, ".FlushCnt"}, 32'(ifc.FlushCnt), 32'(m.flushCnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ctrl(input logic sf, input logic sd, input logic fe,
                          input logic br, input logic [31:0] tgt);
    ifc.StallF = sf; ifc.StallD = sd; ifc.FlushE = fe;
    ifc.PCSrcD = br; ifc.PCBranchD = tgt;
  endtask

  task automatic rand_data();
    ifc.InstrF   = $urandom;
    ifc.CtrlD    = CTRL_W'($urandom);
    ifc.RD1D     = $urandom;
    ifc.RD2D     = $urandom;
    ifc.SignImmD = $urandom;
    ifc.RsD      = 5'($urandom);
    ifc.RtD      = 5'($urandom);
    ifc.RdD      = 5'($urandom);
  endtask

  task automatic tick(input string tag);
    m = model_edge(m);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m = model_reset();
    #2;
    compare_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] heldInstr;

  initial begin
    rst_n = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rand_data();
    m = model_reset();
    #1;
    compare_all("reset_init");
    apply_reset();

    // Free run from reset: PCF walks 4, 8, 12, 16.
    check_eq("run_pcf0", ifc.PCF, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      rand_data();
      tick("run");
      check_eq("run_pcf", ifc.PCF, 32'(4 * i));
      if (i >= 2) check_eq("run_validE", 32'(ifc.ValidE), 32'd1);
    end

    // Load-use hazard at PCF=0x10.
    heldInstr = ifc.InstrD;
    set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    rand_data();
    tick("loaduse");
    check_eq("lu_pcf",    ifc.PCF, 32'h10);
    check_eq("lu_instrD", ifc.InstrD, heldInstr);
    check_eq("lu_ctrlE",  32'(ifc.CtrlE), 32'h0);
    check_eq("lu_validE", 32'(ifc.ValidE), 32'h0);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rand_data();
    tick("lu_resume");
    check_eq("lu_resume_pcf", ifc.PCF, 32'h14);

    // Taken branch without stall squashes D.
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    rand_data();
    tick("branch");
    check_eq("br_pcf",    ifc.PCF, 32'h40);
    check_eq("br_instrD", ifc.InstrD, 32'h0);
    check_eq("br_validD", 32'(ifc.ValidD), 32'h0);

    // Branch under stall is deferred until the stall clears.
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rand_data();
    tick("pre_stallbr");
    heldInstr = ifc.InstrD;
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
    rand_data();
    tick("stallbr");
    check_eq("sb_pcf",    ifc.PCF, 32'h44);
    check_eq("sb_instrD", ifc.InstrD, heldInstr);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    tick("stallbr_rel");
    check_eq("sb_redirect", ifc.PCF, 32'h40);

    // PC wrap at the top of the address space.
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick("wrap_set");
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rand_data();
    tick("wrap");
    check_eq("wrap_pcf", ifc.PCF, 32'h0);

    // Asynchronous reset in the middle of a stall with FlushE held.
    set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick("pre_areset");
    tick("pre_areset");
    apply_reset();
    check_eq("ar_pcf", ifc.PCF, 32'h0);

    // Sustained stall drives StallCnt into saturation when counters exist.
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < CNT_MAX + 5; i++) tick("sat");
`ifdef PIPE_PERF_CNT_EN
    check_eq("sat_stallcnt", 32'(ifc.StallCnt), 32'(CNT_MAX));
`else
    check_eq("sat_stallcnt", 32'(ifc.StallCnt), 32'h0);
`endif

    // Randomized control mix, including the illegal StallF=0/StallD=1 combination.
    for (int i = 0; i < 400; i++) begin
      set_ctrl($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC);
      rand_data();
      tick("rand");
      if (i == 200) apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Consumes the hazard unit's StallF / StallD / FlushE outputs and applies them to the 5-stage MIPS core.
- Holds the PC register, the IF/ID pipeline register and the ID/EX pipeline register.
- Applies hold, bubble and branch-squash semantics to these registers.
- Sits between fetch/decode datapath and the hazard unit. It is the receiving end of the stall/flush interface.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- CTRL_W, 12, width of the packed decode control bundle carried D->E.
- CNT_W, 32, width of the optional stall/flush counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StallF  in  1  hold PC register.
- StallD  in  1  hold IF/ID register.
- FlushE  in  1  load bubble into ID/EX register.
- PCSrcD  in  1  branch taken, resolved in D.
- PCBranchD  in  32  branch target from D.
- InstrF  in  32  instruction from imem at PCF.
- PCF  out  32  current fetch PC.
- InstrD  out  32  IF/ID instruction.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.
- CtrlD  in  CTRL_W  decoded control bundle (RegWrite, MemtoReg, RegDst, ... packed).
- RD1D, RD2D, SignImmD  in  32 each  decode operands.
- RsD, RtD, RdD  in  5 each  register specifiers.
- CtrlE  out  CTRL_W  registered control.
- RD1E, RD2E, SignImmE  out  32 each  registered operands.
- RsE, RtE, RdE  out  5 each  registered specifiers.
- ValidE  out  1  ID/EX holds a real instruction.
- StallCnt, FlushCnt  out  CNT_W each  performance counters (see Optional Feature).

Behaviour:
- Reset, asynchronous on rst_n low, all outputs forced immediately:
  - PCF=RESET_PC.
  - All D and E registers = 0, including ValidD=ValidE=0. InstrD=0 is sll $0 (NOP).
  - Counters = 0.
- PC register, each rising edge:
  - If StallF=1: hold.
  - Else if PCSrcD=1: PCF<=PCBranchD.
  - Else: PCF<=PCF+4. Mod 2^32, wraps 32'hFFFF_FFFC -> 0.
- IF/ID register, priority StallD > PCSrcD > load:
  - StallD=1: hold InstrD, PCPlus4D, ValidD.
  - PCSrcD=1 (and StallD=0): squash. InstrD<=0, PCPlus4D<=0, ValidD<=0. Single branch-delay squash.
  - Otherwise: InstrD<=InstrF, PCPlus4D<=PCF+4, ValidD<=1.
- ID/EX register, priority FlushE > load:
  - FlushE=1: CtrlE<=0, ValidE<=0, all operand and specifier fields <=0. The bubble has RegWrite=0 and MemWrite=0.
  - Otherwise: load all D-side inputs; ValidE<=ValidD.
  - No StallE exists; ID/EX never holds.
- Simultaneous events:
  - StallF&StallD&FlushE (load-use or branch hazard): PC and IF/ID hold, ID/EX gets a bubble. The same instruction re-presents in D the next cycle.
  - StallD&PCSrcD: stall wins; redirect is deferred. D re-evaluates the branch next cycle with forwarded operands.
  - StallF=0 with StallD=1 is illegal from the hazard unit. The block still honours each input independently, with no cross-checking.
- Latency: one cycle per stage. There are no combinational paths from inputs to outputs except reset.
- Reset release: the first fetch edge loads PCF+4. IF/ID captures InstrF at RESET_PC on the same edge.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined:
  - StallCnt increments on every edge with StallD=1.
  - FlushCnt increments on every edge with FlushE=1 or (PCSrcD=1 & StallD=0).
  - Both saturate at all-ones and do not wrap. Both reset to 0.
- When undefined: StallCnt and FlushCnt are constant 0 and no counter flops are built.

Decomposition:
- Shared package (mips_pkg):
  - RESET_PC default.
  - CTRL_W.
  - Control-bundle field index localparams (CTRL_REGWRITE, CTRL_MEMTOREG, CTRL_REGDST, ...).
  - NOP_INSTR=32'h0.
- Sub-module pipe_reg: parameter W, with ports clk, rst_n, en, clr, d, q.
  - Clear has priority over enable.
  - Used for PC, IF/ID and ID/EX.

Test Plan:
- Reset then free-run 4 cycles, no stalls, RESET_PC=0 -> PCF=0,4,8,12. InstrD follows InstrF one cycle later. ValidE=1 from cycle 2.
- Load-use: assert StallF=StallD=FlushE=1 for one cycle with PCF=0x10 -> PCF stays 0x10, InstrD unchanged, CtrlE=0, ValidE=0. Next cycle resumes to 0x14.
- Branch taken: PCSrcD=1, PCBranchD=0x40, no stall -> PCF=0x40 next edge, InstrD=0, ValidD=0.
- StallD=StallF=1 together with PCSrcD=1 -> PCF and InstrD hold. Redirect to 0x40 occurs on the following edge once the stall clears.
- PC wrap: force PCF=0xFFFF_FFFC, free-run -> PCF=0x0000_0000.
- Assert rst_n low mid-stall with FlushE=1 -> all outputs reset immediately, asynchronously. With PIPE_PERF_CNT_EN, counters read 0. Saturation check: preload StallCnt=all-ones, StallD=1 -> value stays all-ones.
